code_loader: RTL and testbench
==============================

# code_loader

Streams a program image from a host byte channel (UART receiver or debug bridge) into the 18-bit code RAM, upstream of `processor`. It holds the processor in reset while the image is loaded and releases it once the checksum verifies. Its write port drives the code RAM write side; its `processor_reset` output drives the processor's `reset` input.

## Interface

Parameters:
- `WORD_SIZE`, 18: code word width. Fixed at 18 by the byte framing.
- `ADDR_SIZE`, 18: code address width.
- `MEM_SIZE`, 1024: code RAM depth in words. This is the maximum legal word count.

Ports:
- `clock` — input, 1 bit. Single clock; all logic is rising-edge.
- `reset` — input, 1 bit. Asynchronous, active-low (0 = reset).
- `rx_data` — input, 8 bits. Host byte.
- `rx_valid` — input, 1 bit. `rx_data` is valid this cycle.
- `rx_ready` — output, 1 bit. Loader accepts a byte. Constant 1 after reset; a byte is consumed on every edge where `rx_valid` = 1.
- `code_we` — output, 1 bit. Code RAM write strobe.
- `code_waddr` — output, `ADDR_SIZE` bits. Write address.
- `code_wdata` — output, `WORD_SIZE` bits. Write data.
- `processor_reset` — output, 1 bit. Active-high reset to the processor.
- `load_done` — output, 1 bit. One-cycle pulse on a successful load.
- `load_error` — output, 1 bit. Sticky error flag.

## Operation

Frame format:
- Header byte 0xA5.
- Word count N: 3 bytes, little-endian.
- N words, each 3 bytes, little-endian (bits 7:0, 15:8, then 17:16 in the low bits of the third byte).
- Checksum byte: 8-bit sum, mod 256, of all word bytes. Header and count bytes are excluded.

States and transitions:
- IDLE: non-0xA5 bytes are discarded. On 0xA5: clear `load_error`, clear checksum, set address to 0, assert `processor_reset`, go to CNT0.
- CNT0, CNT1, CNT2: assemble N. At CNT2, N > `MEM_SIZE` is an error. N = 0 goes directly to CSUM.
- W0, W1, W2: assemble one word. At W2, a third byte with bits 7:2 nonzero is an error. Otherwise the word is written, the address increments, and N decrements. The state returns to W0 while words remain, else goes to CSUM.
- CSUM: on a match, pulse `load_done`, deassert `processor_reset`, go to IDLE. On a mismatch, go to error.

Error handling:
- Set `load_error`, return to IDLE.
- `processor_reset` stays 1, because code memory is now partially overwritten.
- `load_error` clears only when the next header is accepted.

Other rules:
- Bytes arriving while `rx_valid` is low are ignored. Gaps of any length between bytes are legal.
- Checksum arithmetic is 8-bit wrapping. The word counter is `ADDR_SIZE` bits. Addresses never wrap, because N ≤ `MEM_SIZE`.

## Timing

Reset values:
- `rx_ready` = 0 during reset, 1 after.
- `code_we` = 0, `code_waddr` = 0, `code_wdata` = 0.
- `processor_reset` = 0, so a preloaded image runs.
- `load_done` = 0, `load_error` = 0, state = IDLE.

Cycle-level behaviour:
- `code_we`, `code_waddr` and `code_wdata` are registered. They are valid for exactly one cycle, the cycle after the edge that accepts the W2 byte.
- `processor_reset` rises in the cycle after the header is accepted.
- `load_done` = 1 and `processor_reset` = 0 both take effect in the cycle after the checksum byte is accepted. The last word's write always completes at least one cycle earlier.
- Reset asserted mid-frame returns every output to its reset value immediately. That includes `processor_reset` dropping to 0. Words already written remain in RAM.

## Structure

- Package `code_loader_pkg` holds:
  - The state enum (IDLE, CNT0, CNT1, CNT2, W0, W1, W2, CSUM).
  - `LOADER_HEADER` = 8'hA5.
  - `LOADER_HI_MASK` = 8'hFC.
- No sub-module: the single FSM with inline assembly, counter and checksum registers is the natural structure.

## Test plan

- **Basic load.** Stream A5, 01 00 00, CD AB 02, 7A (one byte per cycle) → one write of address 0 with data 2ABCD; `load_done` pulses; `processor_reset` returns to 0.
- **Empty image.** Stream A5, 00 00 00, 00 → no `code_we`; `load_done` pulses; `load_error` = 0.
- **Bad high byte.** Send the third byte of a word as 04 → `load_error` = 1, state IDLE, `processor_reset` held at 1. A following valid frame clears `load_error` on its header.
- **Count too large.** With `MEM_SIZE` = 64, send A5, 41 00 00 → error after CNT2; no writes.
- **Gaps and bad checksum.** Send two words with random `rx_valid` gaps → writes to addresses 0 and 1 with correct data. Then send a wrong checksum → `load_error` = 1, no `load_done`.
- **Reset mid-frame.** Pull `reset` low after W1 → all outputs at reset values. Afterwards the stray bytes are discarded until the next A5.

Source files
------------

// File: rtl/code_loader_pkg.sv
// -----------------------------------------------------------------------------
// code_loader_pkg
//   Shared definitions for the code image loader: FSM state encoding and the
//   framing constants used by the byte-stream parser.
// -----------------------------------------------------------------------------
package code_loader_pkg;

    // Frame parser states. IDLE hunts for the header; CNTx assemble the word
    // count; Wx assemble one 18-bit word; CSUM compares the trailing checksum.
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        CNT0 = 3'd1,
        CNT1 = 3'd2,
        CNT2 = 3'd3,
        W0   = 3'd4,
        W1   = 3'd5,
        W2   = 3'd6,
        CSUM = 3'd7
    } loader_state_e;

    localparam logic [7:0] LOADER_HEADER  = 8'hA5;
    // Bits of the third word byte that must be zero (only 17:16 are carried).
    localparam logic [7:0] LOADER_HI_MASK = 8'hFC;

endpackage : code_loader_pkg

// File: rtl/code_loader.sv
// -----------------------------------------------------------------------------
// code_loader
//   Streams a framed program image from a host byte channel into the code RAM
//   write port, holding the processor in reset while the image is loaded and
//   releasing it once the checksum verifies.
//
//   Frame: A5 | N[7:0] N[15:8] N[23:16] | N x (b0 b1 b2) | checksum
//   Checksum is the mod-256 sum of the word bytes only.
//
// Ports:
//   clock           : rising-edge clock
//   reset           : asynchronous active-low reset
//   rx_data/rx_valid/rx_ready : host byte channel. A byte transfers on every
//                     rising edge where rx_valid = 1 and rx_ready = 1;
//                     rx_ready is held at 1 out of reset, so the loader never
//                     back-pressures the host.
//   code_we/code_waddr/code_wdata : registered code RAM write port
//   processor_reset : active-high reset to the processor
//   load_done       : one-cycle pulse when a frame loads with a good checksum
//   load_error      : sticky error, cleared when the next header is accepted
//   state_debug     : current parser state (loader_state_e encoding)
// -----------------------------------------------------------------------------
module code_loader
    import code_loader_pkg::*;
#(
    parameter int WORD_SIZE = 18,
    parameter int ADDR_SIZE = 18,
    parameter int MEM_SIZE  = 1024
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [7:0]           rx_data,
    input  logic                 rx_valid,
    output logic                 rx_ready,
    output logic                 code_we,
    output logic [ADDR_SIZE-1:0] code_waddr,
    output logic [WORD_SIZE-1:0] code_wdata,
    output logic                 processor_reset,
    output logic                 load_done,
    output logic                 load_error,
    output logic [2:0]           state_debug
);

    // The count field is 24 bits on the wire; compare it at full width so an
    // oversize count cannot alias into range after truncation.
    localparam logic [23:0]          MAX_WORDS = 24'(MEM_SIZE);
    localparam logic [ADDR_SIZE-1:0] ONE       = ADDR_SIZE'(1);

    loader_state_e          state_q, state_d;
    logic [ADDR_SIZE-1:0]   count_q, count_d;   // words still to receive
    logic [ADDR_SIZE-1:0]   addr_q,  addr_d;    // next write address
    logic [7:0]             csum_q,  csum_d;
    logic [7:0]             byte0_q, byte0_d;   // word bits 7:0
    logic [7:0]             byte1_q, byte1_d;   // word bits 15:8
    logic                   we_q,    we_d;
    logic [ADDR_SIZE-1:0]   waddr_q, waddr_d;
    logic [WORD_SIZE-1:0]   wdata_q, wdata_d;
    logic                   prst_q,  prst_d;
    logic                   done_q,  done_d;
    logic                   err_q,   err_d;
    logic                   ready_q;
    logic [23:0]            count_full;

    // Full 24-bit count as it stands when the third count byte arrives.
    assign count_full = {rx_data, count_q[15:0]};

    // ------------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            count_q <= '0;
            addr_q  <= '0;
            csum_q  <= '0;
            byte0_q <= '0;
            byte1_q <= '0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            prst_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            addr_q  <= addr_d;
            csum_q  <= csum_d;
            byte0_q <= byte0_d;
            byte1_q <= byte1_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            prst_q  <= prst_d;
            done_q  <= done_d;
            err_q   <= err_d;
            ready_q <= 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state and output logic. Nothing advances without rx_valid.
    // ------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        addr_d  = addr_q;
        csum_d  = csum_q;
        byte0_d = byte0_q;
        byte1_d = byte1_q;
        we_d    = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        prst_d  = prst_q;
        done_d  = 1'b0;
        err_d   = err_q;

        if (rx_valid) begin
            unique case (state_q)
                IDLE: begin
                    if (rx_data == LOADER_HEADER) begin
                        err_d   = 1'b0;
                        csum_d  = '0;
                        addr_d  = '0;
                        prst_d  = 1'b1;
                        state_d = CNT0;
                    end
                end
                CNT0: begin
                    count_d = ADDR_SIZE'(rx_data);
                    state_d = CNT1;
                end
                CNT1: begin
                    count_d[15:8] = rx_data;
                    state_d       = CNT2;
                end
                CNT2: begin
                    if (count_full > MAX_WORDS) begin
                        // processor_reset is already 1 and stays there.
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end else if (count_full == 24'd0) begin
                        state_d = CSUM;
                    end else begin
                        count_d = ADDR_SIZE'(count_full);
                        state_d = W0;
                    end
                end
                W0: begin
                    byte0_d = rx_data;
                    csum_d  = csum_q + rx_data;
                    state_d = W1;
                end
                W1: begin
                    byte1_d = rx_data;
                    csum_d  = csum_q + rx_data;
                    state_d = W2;
                end
                W2: begin
                    if ((rx_data & LOADER_HI_MASK) != 8'h00) begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end else begin
                        csum_d  = csum_q + rx_data;
                        we_d    = 1'b1;
                        waddr_d = addr_q;
                        wdata_d = WORD_SIZE'({rx_data[1:0], byte1_q, byte0_q});
                        addr_d  = addr_q + ONE;
                        count_d = count_q - ONE;
                        state_d = (count_q == ONE) ? CSUM : W0;
                    end
                end
                CSUM: begin
                    if (rx_data == csum_q) begin
                        done_d = 1'b1;
                        prst_d = 1'b0;
                    end else begin
                        err_d  = 1'b1;
                    end
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign rx_ready        = ready_q;
    assign code_we         = we_q;
    assign code_waddr      = waddr_q;
    assign code_wdata      = wdata_q;
    assign processor_reset = prst_q;
    assign load_done       = done_q;
    assign load_error      = err_q;
    assign state_debug     = state_q;

endmodule : code_loader

// File: tb/tb_code_loader.sv
// -----------------------------------------------------------------------------
// tb_code_loader
//   Self-checking bench for code_loader (MEM_SIZE = 64). Frames are built from
//   random word lists; the expected RAM writes, done pulses and error flags are
//   derived from the frame contents and the injected fault, not from the DUT.
// -----------------------------------------------------------------------------
module tb_code_loader;
    import code_loader_pkg::*;

    localparam int MEM = 64;

    logic        clock;
    logic        reset;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        code_we;
    logic [17:0] code_waddr;
    logic [17:0] code_wdata;
    logic        processor_reset;
    logic        load_done;
    logic        load_error;
    logic [2:0]  state_debug;

    logic [35:0] exp_q[$];     // {addr, data} of expected writes
    logic [35:0] mon_e;
    int          vec_cnt   = 0;
    int          err_cnt   = 0;
    int          done_seen = 0;
    int          exp_done  = 0;

    localparam int F_NONE = 0, F_BAD_HI = 1, F_BAD_CSUM = 2, F_BIG_CNT = 3;

    code_loader #(.WORD_SIZE(18), .ADDR_SIZE(18), .MEM_SIZE(MEM)) dut (
        .clock           (clock),
        .reset           (reset),
        .rx_data         (rx_data),
        .rx_valid        (rx_valid),
        .rx_ready        (rx_ready),
        .code_we         (code_we),
        .code_waddr      (code_waddr),
        .code_wdata      (code_wdata),
        .processor_reset (processor_reset),
        .load_done       (load_done),
        .load_error      (load_error),
        .state_debug     (state_debug)
    );

    // ---------------- clock ----------------
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // ---------------- checker ----------------
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- scoreboard monitor (opposite edge) ----------------
    always @(negedge clock) begin
        if (reset === 1'b1 && code_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("spurious_we", code_we, 1'b0);
            end else begin
                mon_e = exp_q.pop_front();
                check("waddr", code_waddr, mon_e[35:18]);
                check("wdata", code_wdata, mon_e[17:0]);
            end
        end
        if (load_done === 1'b1) done_seen++;
    end

    // ---------------- driver ----------------
    // Called at posedge+1; returns at posedge+1 after the byte was accepted.
    task automatic send_byte(input logic [7:0] b, input int gap);
        repeat ($urandom_range(0, gap)) begin
            rx_valid = 1'b0;
            rx_data  = 8'($urandom);
            @(posedge clock); #1;
        end
        rx_valid = 1'b1;
        rx_data  = b;
        @(posedge clock); #1;
        rx_valid = 1'b0;
    endtask

    // Checks after the last byte of a frame (good or failed), then one idle
    // cycle to let the done counter and write queue settle.
    task automatic post_frame(input bit ok);
        check("done",  load_done,       ok);
        check("prst",  processor_reset, !ok);
        check("err",   load_error,      !ok);
        check("state", state_debug,     3'(IDLE));
        if (ok) exp_done++;
        @(posedge clock); #1;
        check("done_cnt",    done_seen,    exp_done);
        check("writes_left", exp_q.size(), 0);
    endtask

    // Builds and sends one frame. For F_BIG_CNT, n is the count sent.
    task automatic run_frame(input int n, input int fault, input int gap);
        logic [17:0] w;
        logic [7:0]  b2;
        logic [7:0]  sum;
        int          bad_k;
        sum   = 8'h00;
        bad_k = (fault == F_BAD_HI) ? int'($urandom_range(0, n - 1)) : n;
        repeat ($urandom_range(0, 2)) begin
            b2 = 8'($urandom);
            if (b2 == LOADER_HEADER) b2 = 8'h00;
            send_byte(b2, gap);
        end
        check("state_pre", state_debug, 3'(IDLE));
        send_byte(LOADER_HEADER, gap);
        check("hdr_prst", processor_reset, 1'b1);
        check("hdr_err",  load_error,      1'b0);
        send_byte(8'(n),       gap);
        send_byte(8'(n >> 8),  gap);
        send_byte(8'(n >> 16), gap);
        if (fault == F_BIG_CNT) begin
            post_frame(1'b0);
            return;
        end
        for (int i = 0; i < n; i++) begin
            w = 18'($urandom);
            send_byte(w[7:0],  gap);
            send_byte(w[15:8], gap);
            if (i == bad_k) begin
                b2 = {6'($urandom_range(1, 63)), w[17:16]};
                send_byte(b2, gap);
                post_frame(1'b0);
                return;
            end
            exp_q.push_back({18'(i), w});
            b2  = {6'd0, w[17:16]};
            sum = sum + w[7:0] + w[15:8] + b2;
            send_byte(b2, gap);
        end
        if (fault == F_BAD_CSUM) sum = sum + 8'($urandom_range(1, 255));
        send_byte(sum, gap);
        post_frame(fault != F_BAD_CSUM);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int f, n;
        reset    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        repeat (3) @(posedge clock);
        #1;
        check("rst_ready", rx_ready,        1'b0);
        check("rst_prst",  processor_reset, 1'b0);
        check("rst_we",    code_we,         1'b0);
        check("rst_err",   load_error,      1'b0);
        check("rst_state", state_debug,     3'(IDLE));
        reset = 1'b1;
        @(posedge clock); #1;
        check("ready_up", rx_ready,        1'b1);
        check("prst_idle", processor_reset, 1'b0);

        // Basic load from the literal byte sequence.
        exp_q.push_back({18'd0, 18'h2ABCD});
        send_byte(8'hA5, 0);
        check("basic_prst", processor_reset, 1'b1);
        send_byte(8'h01, 0); send_byte(8'h00, 0); send_byte(8'h00, 0);
        send_byte(8'hCD, 0); send_byte(8'hAB, 0); send_byte(8'h02, 0);
        send_byte(8'h7A, 0);
        post_frame(1'b1);

        // Empty image.
        send_byte(8'hA5, 0);
        send_byte(8'h00, 0); send_byte(8'h00, 0); send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        post_frame(1'b1);

        run_frame(2,   F_BAD_HI,   0);   // bad third byte
        run_frame(3,   F_NONE,     0);   // header clears the sticky error
        run_frame(MEM + 1, F_BIG_CNT, 0); // one past the limit
        run_frame(24'h010040, F_BIG_CNT, 1); // only the top byte makes it big
        run_frame(MEM, F_NONE,     0);   // exactly the limit
        run_frame(2,   F_NONE,     3);   // gaps
        run_frame(2,   F_BAD_CSUM, 3);

        // Reset in the middle of a word (after W1).
        send_byte(8'hA5, 0);
        send_byte(8'h02, 0); send_byte(8'h00, 0); send_byte(8'h00, 0);
        send_byte(8'h11, 0); send_byte(8'h22, 0);
        reset = 1'b0;
        #2;
        check("mid_ready", rx_ready,        1'b0);
        check("mid_prst",  processor_reset, 1'b0);
        check("mid_we",    code_we,         1'b0);
        check("mid_waddr", code_waddr,      18'd0);
        check("mid_wdata", code_wdata,      18'd0);
        check("mid_done",  load_done,       1'b0);
        check("mid_err",   load_error,      1'b0);
        check("mid_state", state_debug,     3'(IDLE));
        @(posedge clock); #1;
        reset = 1'b1;
        @(posedge clock); #1;
        send_byte(8'h03, 0); send_byte(8'h33, 1); send_byte(8'h00, 1);
        check("stray_state", state_debug,     3'(IDLE));
        check("stray_prst",  processor_reset, 1'b0);
        @(posedge clock); #1;
        check("stray_writes", exp_q.size(), 0);
        run_frame(1, F_NONE, 1);

        // Randomized frames.
        repeat (12) begin
            f = int'($urandom_range(0, 3));
            n = int'($urandom_range(0, 12));
            if (f == F_BAD_HI && n == 0) n = 1;
            if (f == F_BIG_CNT) n = int'($urandom_range(MEM + 1, 24'hFFFFFF));
            run_frame(n, f, int'($urandom_range(0, 3)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule : tb_code_loader
